// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep {valid,data} register chain with stall, bubble insertion and flush.
// Define PIPE_CHAIN_PERF_EN to build the saturating stall/bubble/flush perf counters.
module pipe_stage_chain #(
    parameter int               STAGES = 4,
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               PERF_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    perf_clr,
    output logic [PERF_W-1:0]       perf_stall,
    output logic [PERF_W-1:0]       perf_bubble,
    output logic [PERF_W-1:0]       perf_flush
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] nv;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [WIDTH-1:0]  nd  [STAGES];

    // A stall freezes its own stage and every stage upstream of it.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    assign in_ready = ~hold[0];

    // Next state per stage: flush beats hold beats load; a moving stage under a frozen one gets a bubble.
    always_comb begin
        nv = vld;
        nd = dat;
        if (!hold[0]) begin
            nv[0] = in_valid;
            nd[0] = in_valid ? in_data : BUBBLE;
        end
        if (flush[0]) begin
            nv[0] = 1'b0;
            nd[0] = BUBBLE;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (!hold[i]) begin
                nv[i] = vld[i-1] & ~hold[i-1];
                nd[i] = hold[i-1] ? BUBBLE : dat[i-1];
            end
            if (flush[i]) begin
                nv[i] = 1'b0;
                nd[i] = BUBBLE;
            end
        end
    end

    // Stage registers; reset empties the whole chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= BUBBLE;
            end
        end else begin
            vld <= nv;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= nd[i];
            end
        end
    end

    // Flatten the stage payloads onto the observation bus.
    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*WIDTH +: WIDTH] = dat[i];
        end
    end

    assign stage_valid = vld;
    assign out_valid   = vld[STAGES-1];
    assign out_data    = dat[STAGES-1];

`ifdef PIPE_CHAIN_PERF_EN
    logic            bub;
    logic [PERF_W:0] kill_cnt;

    // A bubble appears wherever a frozen stage sits directly above a moving one.
    assign bub = |(hold[STAGES-2:0] & ~hold[STAGES-1:1]);

    // Count valid entries that a flush kills this cycle.
    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            kill_cnt = kill_cnt + {{PERF_W{1'b0}}, flush[i] & vld[i]};
        end
    end

    function automatic logic [PERF_W-1:0] sat_add(
        input logic [PERF_W-1:0] a,
        input logic [PERF_W:0]   b
    );
        logic [PERF_W:0] s;
        s = {1'b0, a} + b;
        return s[PERF_W] ? '1 : s[PERF_W-1:0];
    endfunction

    // Saturating perf counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else if (perf_clr) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            perf_stall  <= sat_add(perf_stall, {{PERF_W{1'b0}}, |stall});
            perf_bubble <= sat_add(perf_bubble, {{PERF_W{1'b0}}, bub});
            perf_flush  <= sat_add(perf_flush, kill_cnt);
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_stall  = '0;
    assign perf_bubble = '0;
    assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed vector table, hand sequences and randomized
// traffic checked against a stage-array reference model.
module tb_pipe_stage_chain;

    localparam int          S  = 4;
    localparam int          W  = 32;
    localparam int          PW = 4;
    localparam logic [31:0] BB = 32'hDEAD_BEEF;
    localparam int          SAT = (1 << PW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic [S-1:0]   stall = '0;
    logic [S-1:0]   flush = '0;
    logic [S-1:0]   stage_valid;
    logic [S*W-1:0] stage_data;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           perf_clr = 1'b0;
    logic [PW-1:0]  perf_stall;
    logic [PW-1:0]  perf_bubble;
    logic [PW-1:0]  perf_flush;

    pipe_stage_chain #(
        .STAGES(S), .WIDTH(W), .BUBBLE(BB), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .out_valid(out_valid), .out_data(out_data),
        .perf_clr(perf_clr), .perf_stall(perf_stall),
        .perf_bubble(perf_bubble), .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        mv [S];
    logic [31:0] md [S];
    int          mps, mpb, mpf;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [3:0]  st;
        logic [3:0]  fl;
        logic        rdy;
        logic [3:0]  ev;
        logic [31:0] ed [S];
    } vec_t;

    vec_t vt [13];

    function automatic vec_t mk(
        logic iv, logic [31:0] d, logic [3:0] st, logic [3:0] fl,
        logic rdy, logic [3:0] ev,
        logic [31:0] r0, logic [31:0] r1, logic [31:0] r2, logic [31:0] r3
    );
        vec_t v;
        v.iv = iv; v.d = d; v.st = st; v.fl = fl;
        v.rdy = rdy; v.ev = ev;
        v.ed[0] = r0; v.ed[1] = r1; v.ed[2] = r2; v.ed[3] = r3;
        return v;
    endfunction

    function automatic int expp(int v);
`ifdef PIPE_CHAIN_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int sat(int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = BB;
        end
        mps = 0; mpb = 0; mpf = 0;
    endtask

    // The highest stalled stage and everything above it freeze; the stage just
    // below it receives a bubble; everything further down shifts; flush overrides.
    task automatic model_step();
        int          top;
        int          kill;
        logic        nv [S];
        logic [31:0] nd [S];
        top = -1;
        kill = 0;
        for (int i = 0; i < S; i++) begin
            if (stall[i]) top = i;
            if (flush[i] && mv[i]) kill++;
        end
        for (int i = 0; i < S; i++) begin
            if (i <= top) begin
                nv[i] = mv[i]; nd[i] = md[i];
            end else if (i == 0) begin
                nv[i] = in_valid; nd[i] = in_valid ? in_data : BB;
            end else if (i == top + 1) begin
                nv[i] = 1'b0; nd[i] = BB;
            end else begin
                nv[i] = mv[i-1]; nd[i] = md[i-1];
            end
            if (flush[i]) begin
                nv[i] = 1'b0; nd[i] = BB;
            end
        end
        if (perf_clr) begin
            mps = 0; mpb = 0; mpf = 0;
        end else begin
            mps = sat(mps + ((top >= 0) ? 1 : 0));
            mpb = sat(mpb + ((top >= 0 && top < S - 1) ? 1 : 0));
            mpf = sat(mpf + kill);
        end
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i]; md[i] = nd[i];
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < S; i++) begin
            chk($sformatf("m_valid%0d", i), stage_valid[i], mv[i]);
            chk($sformatf("m_data%0d", i), stage_data[i*W +: W], md[i]);
        end
        chk("m_out_valid", out_valid, mv[S-1]);
        chk("m_out_data", out_data, md[S-1]);
        chk("m_perf_stall", perf_stall, expp(mps));
        chk("m_perf_bubble", perf_bubble, expp(mpb));
        chk("m_perf_flush", perf_flush, expp(mpf));
    endtask

    task automatic cycle();
        #1;
        chk("in_ready", in_ready, stall == '0);
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        in_valid = 1'b0; in_data = '0;
        stall = '0; flush = '0; perf_clr = 1'b0;
    endtask

    initial begin
        int n;
        vt[0]  = mk(1, 32'hA, 4'b0000, 4'b0000, 1, 4'b0001, 32'hA, BB, BB, BB);
        vt[1]  = mk(1, 32'hB, 4'b0000, 4'b0000, 1, 4'b0011, 32'hB, 32'hA, BB, BB);
        vt[2]  = mk(1, 32'hC, 4'b0000, 4'b0000, 1, 4'b0111, 32'hC, 32'hB, 32'hA, BB);
        vt[3]  = mk(1, 32'hD, 4'b0000, 4'b0000, 1, 4'b1111, 32'hD, 32'hC, 32'hB, 32'hA);
        vt[4]  = mk(1, 32'hE, 4'b0010, 4'b0000, 0, 4'b1011, 32'hD, 32'hC, BB, 32'hB);
        vt[5]  = mk(1, 32'hE, 4'b0000, 4'b0000, 1, 4'b0111, 32'hE, 32'hD, 32'hC, BB);
        vt[6]  = mk(1, 32'hF, 4'b0010, 4'b0011, 0, 4'b1000, BB, BB, BB, 32'hC);
        vt[7]  = mk(0, 32'h0, 4'b0000, 4'b0000, 1, 4'b0000, BB, BB, BB, BB);
        vt[8]  = mk(1, 32'h6, 4'b0000, 4'b0000, 1, 4'b0001, 32'h6, BB, BB, BB);
        vt[9]  = mk(0, 32'h0, 4'b0000, 4'b0000, 1, 4'b0010, BB, 32'h6, BB, BB);
        vt[10] = mk(1, 32'h7, 4'b0000, 4'b0000, 1, 4'b0101, 32'h7, BB, 32'h6, BB);
        vt[11] = mk(0, 32'h0, 4'b1000, 4'b0100, 0, 4'b0001, 32'h7, BB, BB, BB);
        vt[12] = mk(0, 32'h0, 4'b0000, 4'b0001, 1, 4'b0010, BB, 32'h7, BB, BB);

        model_reset();
        #12;
        chk("por_valid", stage_valid, 0);
        chk("por_out_data", out_data, BB);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            in_valid = vt[k].iv; in_data = vt[k].d;
            stall = vt[k].st; flush = vt[k].fl;
            #1;
            chk($sformatf("v%0d_ready", k), in_ready, vt[k].rdy);
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", k), stage_valid, vt[k].ev);
            for (int i = 0; i < S; i++) begin
                chk($sformatf("v%0d_data%0d", k, i), stage_data[i*W +: W], vt[k].ed[i]);
            end
            check_model();
        end
        idle();
        chk("tbl_perf_flush", perf_flush, expp(4));
        chk("tbl_perf_stall", perf_stall, expp(3));
        chk("tbl_perf_bubble", perf_bubble, expp(2));

        for (int k = 0; k < S; k++) cycle();
        for (int k = 1; k <= 12; k++) begin
            in_valid = 1'b1; in_data = k;
            cycle();
            chk($sformatf("strm_ov%0d", k), out_valid, k >= 4);
            if (k >= 4) chk($sformatf("strm_od%0d", k), out_data, k - 3);
        end

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", stage_valid, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, BB);
        chk("arst_data", stage_data, {S{BB}});
        stall = 4'b0100;
        #1;
        chk("arst_ready_stall", in_ready, 0);
        stall = '0;
        #1;
        chk("arst_ready_free", in_ready, 1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        in_valid = 1'b1; in_data = 32'h5A5A;
        cycle();
        idle();
        n = 1;
        while (!out_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("latency_edges", n, S);
        chk("latency_data", out_data, 32'h5A5A);

        perf_clr = 1'b1;
        cycle();
        perf_clr = 1'b0;
        stall = 4'b0001;
        for (int k = 0; k < 20; k++) cycle();
        chk("sat_stall", perf_stall, expp(SAT));
        chk("sat_bubble", perf_bubble, expp(SAT));
        stall = '0;
        perf_clr = 1'b1;
        cycle();
        perf_clr = 1'b0;
        chk("clr_stall", perf_stall, 0);
        chk("clr_bubble", perf_bubble, 0);

        for (int k = 0; k < 400; k++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = $urandom;
            stall = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
            flush = ($urandom_range(0, 4) == 0) ? S'($urandom) : '0;
            perf_clr = $urandom_range(0, 49) == 0;
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
